// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default rates and
// the oversampling divider calculation used by both receive and transmit paths.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DEFAULT_CLOCK_RATE = 100000000;
  localparam int DEFAULT_BAUD_RATE  = 9600;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  // System clocks per oversampling tick, truncated toward zero.
  function automatic int calc_div(input int clock_rate, input int baud_rate, input int oversample);
    return clock_rate / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Clock-enable divider: tick is high for one clk every DIV clks.
// A synchronous clear restarts the count so the tick phase can be aligned
// to an external event (e.g. a detected start edge).
`timescale 1ns/1ps
module uart_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Free-running 0..DIV-1 counter, restarted by reset or clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x (parameterisable) oversampling. Start bit is
// confirmed at its midpoint, data and stop bits are sampled one bit period
// apart from there. A low stop bit reports a framing error once, then the
// receiver waits for the line to go high again so a break is not seen as
// a stream of frames.
`timescale 1ns/1ps
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = DEFAULT_CLOCK_RATE,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  if (DIV < 2 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_param_check
    $error("uart_receiver: need DIV >= 2 and an even OVERSAMPLE >= 4");
  end

  logic                 rx_meta_r;
  logic                 rx_sync_r;
  uart_state_t          state_r;
  logic [TW-1:0]        tick_cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 tick_s;
  logic                 div_clear_s;

  // Two-flop synchronizer; idles high like the line itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Restart the divider on the start edge so ticks are phase-aligned to it.
  assign div_clear_s = (state_r == IDLE) && !rx_sync_r;

  uart_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear_s),
    .tick  (tick_s)
  );

  // Receive FSM with registered data and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      tick_cnt_r    <= '0;
      bit_cnt_r     <= '0;
      shift_r       <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_sync_r) begin
            state_r    <= START;
            tick_cnt_r <= '0;
          end
        end
        START: begin
          if (tick_s) begin
            if (tick_cnt_r == HALF_LAST) begin
              // Mid start bit: a high line here was only a glitch.
              tick_cnt_r <= '0;
              bit_cnt_r  <= '0;
              state_r    <= rx_sync_r ? IDLE : DATA;
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            if (tick_cnt_r == FULL_LAST) begin
              tick_cnt_r <= '0;
              shift_r    <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
              bit_cnt_r  <= bit_cnt_r + BW'(1);
              if (bit_cnt_r == BITS_LAST) begin
                state_r <= STOP;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (tick_cnt_r == FULL_LAST) begin
              tick_cnt_r <= '0;
              if (rx_sync_r) begin
                data_out   <= shift_r;
                data_valid <= 1'b1;
                state_r    <= IDLE;
              end else begin
                framing_error <= 1'b1;
                state_r       <= BREAK;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
          end
        end
        BREAK: begin
          if (rx_sync_r) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_r != IDLE);

endmodule
